mode_counter: RTL

Parametrised multi-mode counter: the next-generation replacement for the fixed 4-bit free-running counter used in the practice chapters. Width and modulus are set by parameters. A run-time mode selects up, down, ping-pong or Johnson counting. The block adds enable, synchronous parallel load, a direction flag and a registered terminal-count pulse, so it can serve as a building block for dividers, sequencers and display scanners.

---
 rtl/mode_counter_pkg.sv | 15 +
 rtl/mode_counter_next.sv | 81 ++++++++
 rtl/mode_counter.sv | 77 +++++++
 3 files changed

// File: rtl/mode_counter_pkg.sv
// Shared types and helpers for the multi-mode counter.
package mode_counter_pkg;

  typedef enum logic [1:0] {
    ModeUp       = 2'd0,
    ModeDown     = 2'd1,
    ModePingPong = 2'd2,
    ModeJohnson  = 2'd3
  } mode_e;

  function automatic bit params_legal(int unsigned width, int unsigned modulus);
    return (width >= 2) && (width <= 16) && (modulus >= 2) && (modulus <= (32'd1 << width));
  endfunction

endpackage

// File: rtl/mode_counter_next.sv
// Combinational step function: next count, next direction and wrap flag per mode.
module mode_counter_next
  import mode_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MOD   = 10
) (
  input  logic [WIDTH-1:0] cnt_i,
  input  logic             dir_i,
  input  logic [1:0]       mode_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             dir_o,
  output logic             wrap_o
);

  localparam logic [WIDTH-1:0] CntMax  = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] CntTurn = WIDTH'(MOD - 2);

  logic [31:0]      cnt_ext;
  logic             at_top;
  logic             above;
  logic             at_zero;
  logic [WIDTH-1:0] johnson_nxt;

  // Compare in 32 bits so MOD = 2^WIDTH works without overflow.
  assign cnt_ext     = 32'(cnt_i);
  assign at_top      = cnt_ext >= (MOD - 32'd1);
  assign above       = cnt_ext >= MOD;
  assign at_zero     = (cnt_i == '0);
  assign johnson_nxt = {cnt_i[WIDTH-2:0], ~cnt_i[WIDTH-1]};

  always_comb begin
    cnt_o  = cnt_i;
    dir_o  = dir_i;
    wrap_o = 1'b0;
    unique case (mode_e'(mode_i))
      ModeUp: begin
        if (at_top) begin
          cnt_o  = '0;
          wrap_o = 1'b1;
        end else begin
          cnt_o = cnt_i + WIDTH'(1);
        end
      end
      ModeDown: begin
        if (at_zero || above) begin
          cnt_o  = CntMax;
          wrap_o = 1'b1;
        end else begin
          cnt_o = cnt_i - WIDTH'(1);
        end
      end
      ModePingPong: begin
        if (!dir_i) begin
          if (at_top) begin
            cnt_o  = CntTurn;
            dir_o  = 1'b1;
            wrap_o = 1'b1;
          end else begin
            cnt_o = cnt_i + WIDTH'(1);
          end
        end else if (at_zero) begin
          cnt_o  = WIDTH'(1);
          dir_o  = 1'b0;
          wrap_o = 1'b1;
        end else if (above) begin
          // Recovery from a stale out-of-range value, not a turnaround.
          cnt_o = CntMax;
        end else begin
          cnt_o = cnt_i - WIDTH'(1);
        end
      end
      ModeJohnson: begin
        cnt_o  = johnson_nxt;
        wrap_o = (johnson_nxt == '0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mode_counter.sv
// Multi-mode counter top: state registers, load/enable priority and load clamp.
module mode_counter
  import mode_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MOD   = 10
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             EN,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
  input  logic [1:0]       MODE,
  output logic [WIDTH-1:0] CNT,
  output logic             TC,
  output logic             DIR
);

  if (!params_legal(WIDTH, MOD)) begin : g_param_check
    $error("mode_counter: WIDTH must be 2..16 and MOD 2..2^WIDTH");
  end

  localparam logic [WIDTH-1:0] CntMax = WIDTH'(MOD - 1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] step_cnt;
  logic             step_dir;
  logic             step_wrap;
  logic [WIDTH-1:0] ld_val;

  mode_counter_next #(
    .WIDTH(WIDTH),
    .MOD  (MOD)
  ) u_next (
    .cnt_i (cnt_q),
    .dir_i (dir_q),
    .mode_i(MODE),
    .cnt_o (step_cnt),
    .dir_o (step_dir),
    .wrap_o(step_wrap)
  );

  // Johnson loads are raw patterns; modulus modes clamp into range.
  assign ld_val = ((mode_e'(MODE) != ModeJohnson) && (32'(D) > (MOD - 32'd1))) ? CntMax : D;

  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    tc_d  = 1'b0;
    if (LD) begin
      cnt_d = ld_val;
    end else if (EN) begin
      cnt_d = step_cnt;
      dir_d = step_dir;
      tc_d  = step_wrap;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
      dir_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
      dir_q <= dir_d;
    end
  end

  assign CNT = cnt_q;
  assign TC  = tc_q;
  assign DIR = dir_q;

endmodule
